error_fix_pipe: RTL

Parametrised, pipelined single-error corrector for the decoder path. It takes a received codeword together with the syndrome and error count produced upstream, and flips the bit the syndrome points to. It supports three codeword sizes selectable per word, a valid/ready handshake with full back-pressure, and saturating correction statistics. It replaces the fixed 32-bit, single-register fix stage ahead of the decoder output register.

---
 rtl/ecc_fix_pkg.sv | 31 +++
 rtl/syn_to_mask.sv | 51 +++++
 rtl/error_fix_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ecc_fix_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ecc_fix_pkg : shared encodings and helpers for the error-fix pipe
// Rev 1.0
// ------------------------------------------------------------------
package ecc_fix_pkg;

   typedef enum logic [1:0] {
      MODE_8   = 2'b00,
      MODE_16  = 2'b01,
      MODE_32  = 2'b10,
      MODE_ILL = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_CLEAN  = 2'b00,
      ST_CORR   = 2'b01,
      ST_UNCORR = 2'b10
   } status_e;

   // The illegal mode reports the full 32-bit width so its data passes unmasked.
   function automatic logic [7:0] width_of(input logic [1:0] mode);
      case (mode)
         MODE_8:  return 8'd8;
         MODE_16: return 8'd16;
         default: return 8'd32;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/syn_to_mask.sv
`default_nettype none
// ------------------------------------------------------------------
// syn_to_mask : decodes syndrome/error count/mode into flip mask and status
// Rev 1.0
// ------------------------------------------------------------------
module syn_to_mask
   import ecc_fix_pkg::*;
#(
   parameter int CW_MAX    = 32,
   parameter int SYN_WIDTH = 6
) (
   input  logic [SYN_WIDTH-1:0] i_syn,
   input  logic [1:0]           i_nof,
   input  logic [1:0]           i_mode,
   output logic [CW_MAX-1:0]    o_mask,
   output logic [1:0]           o_status,
   output logic [SYN_WIDTH-1:0] o_pos
);

   logic [SYN_WIDTH-1:0] w_idx;
   logic                 w_in_range;

   // Positional Hamming: syndrome s points at bit s-1, zero means no position.
   assign w_idx      = i_syn - SYN_WIDTH'(1);
   assign w_in_range = (i_syn != '0) && (32'(i_syn) <= 32'(width_of(i_mode)));

   always_comb begin
      o_mask   = '0;
      o_status = ST_CLEAN;
      o_pos    = '0;
      if (i_mode == MODE_ILL) begin
         o_status = ST_UNCORR;
      end else begin
         case (i_nof)
            2'd0: o_status = ST_CLEAN;
            2'd1: begin
               if (w_in_range) begin
                  o_mask   = CW_MAX'(1) << w_idx;
                  o_status = ST_CORR;
                  o_pos    = w_idx;
               end else begin
                  o_status = ST_UNCORR;
               end
            end
            default: o_status = ST_UNCORR;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/error_fix_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// error_fix_pipe : two-stage single-error corrector with valid/ready and stats
// Rev 1.0
// ------------------------------------------------------------------
module error_fix_pipe
   import ecc_fix_pkg::*;
#(
   parameter int CW_MAX    = 32,
   parameter int SYN_WIDTH = 6,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CW_MAX-1:0]    in_data,
   input  logic [SYN_WIDTH-1:0] in_syn,
   input  logic [1:0]           in_nof,
   input  logic [1:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW_MAX-1:0]    out_data,
   output logic [1:0]           out_status,
   output logic [SYN_WIDTH-1:0] out_pos,
   input  logic                 cnt_clr,
   output logic [CNT_WIDTH-1:0] corr_cnt,
   output logic [CNT_WIDTH-1:0] uncorr_cnt
);

   logic [CW_MAX-1:0]    w_mask;
   logic [1:0]           w_status;
   logic [SYN_WIDTH-1:0] w_pos;
   logic [CW_MAX-1:0]    w_dmask;
   logic                 w_s1_load;
   logic                 w_s2_load;
   logic                 w_out_hs;

   logic                 r_s1_valid;
   logic [CW_MAX-1:0]    r_s1_data;
   logic [CW_MAX-1:0]    r_s1_mask;
   logic [1:0]           r_s1_status;
   logic [SYN_WIDTH-1:0] r_s1_pos;

   logic                 r_s2_valid;
   logic [CW_MAX-1:0]    r_s2_data;
   logic [1:0]           r_s2_status;
   logic [SYN_WIDTH-1:0] r_s2_pos;

   logic [CNT_WIDTH-1:0] r_corr_cnt;
   logic [CNT_WIDTH-1:0] r_uncorr_cnt;

   syn_to_mask #(
      .CW_MAX    (CW_MAX),
      .SYN_WIDTH (SYN_WIDTH)
   ) u_syn_to_mask (
      .i_syn    (in_syn),
      .i_nof    (in_nof),
      .i_mode   (in_mode),
      .o_mask   (w_mask),
      .o_status (w_status),
      .o_pos    (w_pos)
   );

   always_comb begin
      w_dmask = '0;
      for (int i = 0; i < CW_MAX; i++) begin
         w_dmask[i] = (i < int'(width_of(in_mode)));
      end
   end

   assign w_s2_load = !r_s2_valid || out_ready;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign w_out_hs  = r_s2_valid && out_ready;
   assign in_ready  = w_s1_load;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_mask   <= '0;
         r_s1_status <= '0;
         r_s1_pos    <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_data   <= in_data & w_dmask;
            r_s1_mask   <= w_mask;
            r_s1_status <= w_status;
            r_s1_pos    <= w_pos;
         end
      end
   end

   // Output registers only change on a load carrying a word, so they hold under stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_data   <= '0;
         r_s2_status <= '0;
         r_s2_pos    <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data   <= r_s1_data ^ r_s1_mask;
            r_s2_status <= r_s1_status;
            r_s2_pos    <= r_s1_pos;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_corr_cnt   <= '0;
         r_uncorr_cnt <= '0;
      end else if (cnt_clr) begin
         r_corr_cnt   <= '0;
         r_uncorr_cnt <= '0;
      end else if (w_out_hs) begin
         if (r_s2_status == ST_CORR && r_corr_cnt != {CNT_WIDTH{1'b1}}) begin
            r_corr_cnt <= r_corr_cnt + CNT_WIDTH'(1);
         end
         if (r_s2_status == ST_UNCORR && r_uncorr_cnt != {CNT_WIDTH{1'b1}}) begin
            r_uncorr_cnt <= r_uncorr_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign out_valid  = r_s2_valid;
   assign out_data   = r_s2_data;
   assign out_status = r_s2_status;
   assign out_pos    = r_s2_pos;
   assign corr_cnt   = r_corr_cnt;
   assign uncorr_cnt = r_uncorr_cnt;

endmodule
`default_nettype wire
